io_counter_checker: RTL and testbench

Receive-side counterpart to the board counter pattern: samples a free-running counter value driven onto the io_in pins by an external sender (another fabric design or board), together with a toggle strobe. Verifies that each new word is exactly the previous word + 1 (mod 2^W). Reports lock state plus good/error tallies for debugging pin integrity and timing across the FABulous IO boundary. Sits directly behind the top-level io_in bus; its status outputs are routed to io_out by the top wrapper.

---
 rtl/io_counter_checker_pkg.sv | 14 +
 rtl/io_sync_bit.sv | 24 ++
 rtl/io_counter_checker.sv | 134 +++++++++++++
 tb/tb_io_counter_checker.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_counter_checker_pkg.sv
// Shared types and default widths for the IO counter checker.
// The top-level wrapper reuses DEF_W / DEF_CNT_W for its io_out mapping.
package io_counter_checker_pkg;

    localparam int unsigned DEF_W     = 16;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNCING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

endpackage

// File: rtl/io_sync_bit.sv
// N-flop synchronizer for one asynchronous bit.
// The whole chain is exposed so callers can tap adjacent stages.
module io_sync_bit #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_i,
    output logic [N-1:0] chain_o
);

    logic [N-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[N-2:0], d_i};
        end
    end

    assign chain_o = chain_q;

endmodule

// File: rtl/io_counter_checker.sv
// Receive-side checker for a free-running counter arriving on io_in.
// Tracks lock on a +1 stream and keeps saturating good/error tallies.
module io_counter_checker
    import io_counter_checker_pkg::*;
#(
    parameter int unsigned W          = DEF_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_LIMIT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     rx_data,
    input  logic             rx_tgl,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [W-1:0]     last_value,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W = $clog2(ERR_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(ERR_LIMIT - 1);

    logic [2:0]   tgl_s;
    logic         ev;
    logic         unused_t1;
    logic [W-1:0] d2;
    logic [W-1:0] unused_d1;
    logic [W-1:0] nxt;
    logic         match;

    io_sync_bit #(.N(3)) u_sync_tgl (
        .clk     (clk),
        .rst     (rst),
        .d_i     (rx_tgl),
        .chain_o (tgl_s)
    );

    assign ev        = tgl_s[1] ^ tgl_s[2];
    assign unused_t1 = tgl_s[0];

    for (genvar i = 0; i < W; i++) begin : g_data
        logic [1:0] ch;
        io_sync_bit #(.N(2)) u_sync_d (
            .clk     (clk),
            .rst     (rst),
            .d_i     (rx_data[i]),
            .chain_o (ch)
        );
        assign d2[i]        = ch[1];
        assign unused_d1[i] = ch[0];
    end

    state_e           state_q;
    logic [RUN_W-1:0] run_q;
    logic [BAD_W-1:0] bad_q;
    logic [W-1:0]     last_q;
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] err_q;
    logic             locked_q;
    logic             pulse_q;

    // last_q doubles as the previous word for the +1 compare
    assign nxt   = last_q + W'(1);
    assign match = (d2 == nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_UNLOCKED;
            run_q    <= '0;
            bad_q    <= '0;
            last_q   <= '0;
            good_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (ev) begin
                last_q <= d2;
                unique case (state_q)
                    ST_UNLOCKED: begin
                        run_q   <= '0;
                        state_q <= ST_SYNCING;
                    end
                    ST_SYNCING: begin
                        if (!match) begin
                            run_q <= '0;
                        end else if (run_q == RUN_LAST) begin
                            run_q    <= '0;
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            bad_q <= '0;
                            if (good_q != '1) good_q <= good_q + CNT_W'(1);
                        end else begin
                            pulse_q <= 1'b1;
                            if (err_q != '1) err_q <= err_q + CNT_W'(1);
                            if (bad_q == BAD_LAST) begin
                                bad_q    <= '0;
                                state_q  <= ST_UNLOCKED;
                                locked_q <= 1'b0;
                            end else begin
                                bad_q <= bad_q + BAD_W'(1);
                            end
                        end
                    end
                    default: state_q <= ST_UNLOCKED;
                endcase
            end
            // a clear wins over any increment on the same edge
            if (clr_cnt) begin
                good_q <= '0;
                err_q  <= '0;
            end
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = pulse_q;
    assign last_value = last_q;
    assign good_count = good_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_io_counter_checker.sv
// Randomized self-checking bench for io_counter_checker.
// Expected values come from a word-level model of the lock/tally rules.
module tb_io_counter_checker;

    localparam int W          = 16;
    localparam int CNT_W      = 16;
    localparam int LOCK_COUNT = 4;
    localparam int ERR_LIMIT  = 3;
    localparam int VW         = 1 + W + 2 * CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     rx_data;
    logic             rx_tgl;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [W-1:0]     last_value;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    io_counter_checker #(
        .W(W), .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_tgl     (rx_tgl),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .last_value (last_value),
        .good_count (good_count),
        .err_count  (err_count)
    );

    int vectors     = 0;
    int miscompares = 0;
    int obs_pulses  = 0;

    always @(negedge clk) if (!rst && err_pulse) obs_pulses++;

    // Word-level reference model
    localparam int M_UNLOCK = 0, M_SYNC = 1, M_LOCK = 2;
    localparam int MAXC = (1 << CNT_W) - 1;
    int m_mode, m_run, m_bad, m_last, m_good, m_err, m_pulses;

    function void model_reset();
        m_mode = M_UNLOCK; m_run = 0; m_bad = 0;
        m_last = 0; m_good = 0; m_err = 0;
        m_pulses = obs_pulses;
    endfunction

    function void model_word(input int w);
        bit inc;
        inc = (w == ((m_last + 1) % (1 << W)));
        if (m_mode == M_UNLOCK) begin
            m_mode = M_SYNC; m_run = 0;
        end else if (m_mode == M_SYNC) begin
            if (!inc) m_run = 0;
            else begin
                m_run++;
                if (m_run == LOCK_COUNT) begin m_mode = M_LOCK; m_run = 0; end
            end
        end else begin
            if (inc) begin
                if (m_good < MAXC) m_good++;
                m_bad = 0;
            end else begin
                if (m_err < MAXC) m_err++;
                m_pulses++;
                m_bad++;
                if (m_bad == ERR_LIMIT) begin m_mode = M_UNLOCK; m_bad = 0; end
            end
        end
        m_last = w;
    endfunction

    function logic [VW-1:0] exp_vec();
        return {m_mode == M_LOCK, W'(m_last), CNT_W'(m_good), CNT_W'(m_err)};
    endfunction

    task automatic do_reset();
        rst = 1'b1; rx_tgl = 1'b0; rx_data = '0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // data settles 4 clk before the toggle and stays 8 clk after it
    task automatic drive_word(input logic [W-1:0] w);
        @(negedge clk);
        rx_data = w;
        repeat (4) @(negedge clk);
        rx_tgl = ~rx_tgl;
        model_word(int'(w));
    endtask

    task automatic send_word(input logic [W-1:0] w);
        drive_word(w);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if ({locked, err_pulse, last_value, good_count, err_count} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got l=%b p=%b v=%h g=%0d e=%0d want all 0",
                         i, locked, err_pulse, last_value, good_count, err_count);
            end
        end
    endtask

    task automatic test_lock_seq();
        do_reset();
        for (int w = 'h10; w <= 'h16; w++) begin
            send_word(W'(w));
            vectors++;
            if (locked !== (w >= 'h14) ||
                {locked, last_value, good_count, err_count} !== exp_vec()) begin
                miscompares++;
                $display("FAIL lock_seq w=%h: got %h want %h (locked %b)",
                         w, {locked, last_value, good_count, err_count}, exp_vec(), locked);
            end
        end
        vectors++;
        if (good_count !== 2 || last_value !== 16'h0016 || err_count !== 0) begin
            miscompares++;
            $display("FAIL lock_final: got g=%0d v=%h e=%0d want g=2 v=0016 e=0",
                     good_count, last_value, err_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int w = 'hFFF9; w <= 'hFFFF; w++) send_word(W'(w));
        send_word(16'h0000);
        vectors++;
        if (good_count !== 3 || err_count !== 0 || locked !== 1'b1 ||
            last_value !== 16'h0000 || {locked, last_value, good_count, err_count} !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap: got l=%b v=%h g=%0d e=%0d want l=1 v=0000 g=3 e=0",
                     locked, last_value, good_count, err_count);
        end
    endtask

    task automatic test_single_err();
        int p0;
        do_reset();
        for (int w = 'hFC; w <= 'h100; w++) send_word(W'(w));
        p0 = obs_pulses;
        send_word(16'h0105);
        vectors++;
        if (err_count !== 1 || obs_pulses - p0 !== 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL single_err: got e=%0d pulses=%0d l=%b want e=1 pulses=1 l=1",
                     err_count, obs_pulses - p0, locked);
        end
        send_word(16'h0106);
        vectors++;
        if (good_count !== 1 || locked !== 1'b1 ||
            {locked, last_value, good_count, err_count} !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_err_recover: got g=%0d l=%b want g=1 l=1",
                     good_count, locked);
        end
    endtask

    task automatic test_unlock();
        bit seen;
        do_reset();
        for (int w = 'h1F0; w <= 'h1F4; w++) send_word(W'(w));
        send_word(16'h0200);
        send_word(16'h0300);
        drive_word(16'h0400);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (err_pulse) seen = 1'b1;
        end
        vectors++;
        if (!seen || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL unlock_edge: got pulse_seen=%b locked=%b want 1 0", seen, locked);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (err_count !== 3 || {locked, last_value, good_count, err_count} !== exp_vec() ||
            obs_pulses !== m_pulses) begin
            miscompares++;
            $display("FAIL unlock_tally: got e=%0d pulses=%0d want e=3 pulses=%0d",
                     err_count, obs_pulses, m_pulses);
        end
        for (int w = 'h401; w <= 'h405; w++) begin
            send_word(W'(w));
            vectors++;
            if ({locked, last_value, good_count, err_count} !== exp_vec()) begin
                miscompares++;
                $display("FAIL relock w=%h: got %h want %h", w,
                         {locked, last_value, good_count, err_count}, exp_vec());
            end
        end
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_final: got locked=%b want 1", locked);
        end
    endtask

    task automatic test_clr_err();
        // still locked from the previous scenario
        drive_word(16'h0500);
        @(negedge clk);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        m_good = 0;
        m_err  = 0;
        vectors++;
        if (err_count !== 0 || good_count !== 0 || err_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_vs_err: got e=%0d g=%0d p=%b want e=0 g=0 p=1",
                     err_count, good_count, err_pulse);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (locked !== 1'b1 || {locked, last_value, good_count, err_count} !== exp_vec() ||
            obs_pulses !== m_pulses) begin
            miscompares++;
            $display("FAIL clr_after: got %h pulses=%0d want %h pulses=%0d",
                     {locked, last_value, good_count, err_count}, obs_pulses,
                     exp_vec(), m_pulses);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        send_word(16'h0010);
        send_word(16'h0011);
        rst = 1'b1; rx_tgl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({locked, err_pulse, last_value, good_count, err_count} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: got l=%b p=%b v=%h g=%0d e=%0d want all 0",
                     locked, err_pulse, last_value, good_count, err_count);
        end
        rst = 1'b0;
        model_reset();
        for (int w = 'h20; w <= 'h24; w++) send_word(W'(w));
        vectors++;
        if (locked !== 1'b1 || {locked, last_value, good_count, err_count} !== exp_vec()) begin
            miscompares++;
            $display("FAIL rst_relock: got %h want %h",
                     {locked, last_value, good_count, err_count}, exp_vec());
        end
    endtask

    task automatic test_random();
        int w;
        int r;
        do_reset();
        w = int'($urandom_range(0, (1 << W) - 1));
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 11));
            if (r < 9)       w = (w + 1) % (1 << W);
            else if (r == 9) w = w;
            else if (r == 10) w = (w + 2) % (1 << W);
            else             w = int'($urandom_range(0, (1 << W) - 1));
            send_word(W'(w));
            vectors++;
            if ({locked, last_value, good_count, err_count} !== exp_vec() ||
                obs_pulses !== m_pulses) begin
                miscompares++;
                $display("FAIL random n=%0d: got %h pulses=%0d want %h pulses=%0d", n,
                         {locked, last_value, good_count, err_count}, obs_pulses,
                         exp_vec(), m_pulses);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_wrap();
        test_single_err();
        test_unlock();
        test_clr_err();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
